// File: rtl/mem_access_pkg.sv
// Shared load/store definitions for the memory-access stage: op encodings,
// widths, zero constants and small decode helpers.
package mem_access_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [XLEN-1:0]   ZERO_XLEN = '0;
  localparam logic [REG_AW-1:0] ZERO_REG  = '0;

  localparam logic [3:0] LS_NONE = 4'd0;
  localparam logic [3:0] LS_LB   = 4'd1;
  localparam logic [3:0] LS_LH   = 4'd2;
  localparam logic [3:0] LS_LW   = 4'd3;
  localparam logic [3:0] LS_LD   = 4'd4;
  localparam logic [3:0] LS_LBU  = 4'd5;
  localparam logic [3:0] LS_LHU  = 4'd6;
  localparam logic [3:0] LS_LWU  = 4'd7;
  localparam logic [3:0] LS_SB   = 4'd8;
  localparam logic [3:0] LS_SH   = 4'd9;
  localparam logic [3:0] LS_SW   = 4'd10;
  localparam logic [3:0] LS_SD   = 4'd11;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [3:0]        op;
    logic [2:0]        off;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_ena;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [7:0]        wmask;
  } req_t;

  function automatic logic is_load(logic [3:0] op);
    return (op >= LS_LB) && (op <= LS_LWU);
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return (op >= LS_SB) && (op <= LS_SD);
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(logic [3:0] op);
    case (op)
      LS_LB, LS_LBU, LS_SB: return 2'd0;
      LS_LH, LS_LHU, LS_SH: return 2'd1;
      LS_LW, LS_LWU, LS_SW: return 2'd2;
      default:              return 2'd3;
    endcase
  endfunction

  // Byte offset with the bits below natural alignment cleared.
  function automatic logic [2:0] eff_off(logic [3:0] op, logic [2:0] a);
    case (op_size(op))
      2'd0:    return a;
      2'd1:    return {a[2:1], 1'b0};
      2'd2:    return {a[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] store_mask(logic [3:0] op, logic [2:0] off);
    if (!is_store(op)) return 8'h00;
    case (op_size(op))
      2'd0:    return 8'h01 << off;
      2'd1:    return 8'h03 << off;
      2'd2:    return 8'h0F << off;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension from an 8-byte aligned read word.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh   = rdata >> {off, 3'b000};
    data = ZERO_XLEN;
    case (op)
      LS_LB:   data = {{56{sh[7]}},  sh[7:0]};
      LS_LH:   data = {{48{sh[15]}}, sh[15:0]};
      LS_LW:   data = {{32{sh[31]}}, sh[31:0]};
      LS_LD:   data = sh;
      LS_LBU:  data = {56'd0, sh[7:0]};
      LS_LHU:  data = {48'd0, sh[15:0]};
      LS_LWU:  data = {32'd0, sh[31:0]};
      default: data = ZERO_XLEN;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one dmem request per load/store, stalls
// until ack, registers the writeback slot. Option: YSYX22040228_MISALIGN_EN.
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [3:0]        ex_ls_op,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [XLEN-1:0]   ex_rd_data,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_rd_ena,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   mem_rd_data,
  output logic [REG_AW-1:0] mem_rd_addr,
  output logic              mem_rd_ena,
  output logic [XLEN-1:0]   mem_pc,
  output logic              mem_valid,
  output logic              stall_req
`ifdef YSYX22040228_MISALIGN_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e          state_q, state_d;
  req_t            cur, req_q, req_act;
  logic            ex_mem, ex_mis, done;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    cur         = '0;
    cur.pc      = ex_pc;
    cur.op      = ex_ls_op;
    cur.off     = eff_off(ex_ls_op, ex_addr[2:0]);
    cur.rd_addr = ex_rd_addr;
    cur.rd_ena  = ex_rd_ena;
    cur.we      = is_store(ex_ls_op);
    cur.addr    = {ex_addr[XLEN-1:3], 3'b000};
    cur.wdata   = ex_store_data << {cur.off, 3'b000};
    cur.wmask   = store_mask(ex_ls_op, cur.off);
  end

  assign ex_mem = ex_valid && (is_load(ex_ls_op) || is_store(ex_ls_op));

`ifdef YSYX22040228_MISALIGN_EN
  assign ex_mis = ex_mem && (eff_off(ex_ls_op, ex_addr[2:0]) != ex_addr[2:0]);
`else
  assign ex_mis = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dmem_req  = 1'b0;
    stall_req = 1'b0;
    req_act   = cur;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_mem && !ex_mis) begin
          dmem_req  = 1'b1;
          stall_req = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // request fields come from the copy taken at issue so they cannot move
        req_act   = req_q;
        dmem_req  = 1'b1;
        stall_req = !dmem_ack;
        if (dmem_ack) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dmem_we    = req_act.we;
  assign dmem_addr  = req_act.addr;
  assign dmem_wdata = req_act.wdata;
  assign dmem_wmask = req_act.wmask;

  mem_load_align u_align (
    .op    (req_q.op),
    .off   (req_q.off),
    .rdata (dmem_rdata),
    .data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      mem_valid   <= 1'b0;
      mem_pc      <= ZERO_XLEN;
      mem_rd_data <= ZERO_XLEN;
      mem_rd_addr <= ZERO_REG;
      mem_rd_ena  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) req_q <= cur;
      mem_valid   <= 1'b0;
      mem_pc      <= ZERO_XLEN;
      mem_rd_data <= ZERO_XLEN;
      mem_rd_addr <= ZERO_REG;
      mem_rd_ena  <= 1'b0;
      if (done) begin
        mem_valid <= 1'b1;
        mem_pc    <= req_q.pc;
        if (is_load(req_q.op)) begin
          mem_rd_data <= ld_data;
          mem_rd_addr <= req_q.rd_addr;
          mem_rd_ena  <= req_q.rd_ena && (req_q.rd_addr != ZERO_REG);
        end
      end else if (state_q == S_IDLE && ex_valid && !stall_req) begin
        mem_valid <= 1'b1;
        mem_pc    <= ex_pc;
        // a misaligned access retires as a slot with no register write
        if (!ex_mis) begin
          mem_rd_data <= ex_rd_data;
          mem_rd_addr <= ex_rd_addr;
          mem_rd_ena  <= ex_rd_ena && (ex_rd_addr != ZERO_REG);
        end
      end
    end
  end

`ifdef YSYX22040228_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= (state_q == S_IDLE) && ex_mis;
  end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_addr, ex_store_data, ex_rd_data;
  logic [3:0]  ex_ls_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_ena;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;
  logic [63:0] mem_rd_data, mem_pc;
  logic [4:0]  mem_rd_addr;
  logic        mem_rd_ena, mem_valid, stall_req;
`ifdef YSYX22040228_MISALIGN_EN
  logic        misalign;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ls_op(ex_ls_op),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd_data(ex_rd_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_ena(ex_rd_ena), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_ena(mem_rd_ena),
    .mem_pc(mem_pc), .mem_valid(mem_valid), .stall_req(stall_req)
`ifdef YSYX22040228_MISALIGN_EN
    , .misalign(misalign)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one load/store, ack it dly cycles after issue, return the request
  // seen at issue, stall cycle count and whether the request held steady.
  task automatic mem_txn(input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [63:0] rdata,
                         input int dly, output logic [63:0] o_addr,
                         output logic [63:0] o_wdata, output logic [7:0] o_mask,
                         output logic o_we, output int stalls, output logic stable);
    logic [200:0] snap;
    tick();
    ex_valid = 1'b1; ex_ls_op = op; ex_addr = addr; ex_store_data = sdata;
    ex_pc = addr ^ 64'h1111; ex_rd_addr = 5'd7; ex_rd_ena = 1'b1;
    dmem_rdata = 64'h5555_5555_5555_5555;
    #1;
    o_addr = dmem_addr; o_wdata = dmem_wdata; o_mask = dmem_wmask; o_we = dmem_we;
    snap   = {dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata};
    stalls = int'(stall_req);
    stable = dmem_req;
    for (int k = 1; k <= dly; k++) begin
      tick();
      if (k == dly) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      #1;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata} !== snap) stable = 1'b0;
      if (mem_valid !== 1'b0) stable = 1'b0;
      stalls += int'(stall_req);
    end
    tick();
    dmem_ack = 1'b0; ex_valid = 1'b0; dmem_rdata = '0;
    #1;
  endtask

  logic [63:0] a, w;
  logic [7:0]  m;
  logic        we, st;
  int          ns;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_ls_op = LS_NONE; ex_addr = '0;
    ex_store_data = '0; ex_rd_data = '0; ex_rd_addr = '0; ex_rd_ena = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_pc", mem_pc, 64'd0);
    chk("rst_rd_data", mem_rd_data, 64'd0);
    chk("rst_req", 64'(dmem_req), 64'd0);
    rst = 1'b0;

    // non-memory pass-through, 1-cycle latency
    tick();
    ex_valid = 1'b1; ex_ls_op = LS_NONE; ex_pc = 64'h1000; ex_rd_data = 64'hDEAD_BEEF;
    ex_rd_addr = 5'd5; ex_rd_ena = 1'b1;
    #1;
    chk("none_req", 64'(dmem_req), 64'd0);
    chk("none_stall", 64'(stall_req), 64'd0);
    tick();
    chk("none_valid", 64'(mem_valid), 64'd1);
    chk("none_pc", mem_pc, 64'h1000);
    chk("none_data", mem_rd_data, 64'hDEAD_BEEF);
    chk("none_addr", 64'(mem_rd_addr), 64'd5);
    chk("none_ena", 64'(mem_rd_ena), 64'd1);
    ex_rd_addr = 5'd0;
    tick();
    chk("x0_ena", 64'(mem_rd_ena), 64'd0);
    chk("x0_valid", 64'(mem_valid), 64'd1);
    ex_valid = 1'b0;
    tick();
    chk("bubble_valid", 64'(mem_valid), 64'd0);
    chk("bubble_data", mem_rd_data, 64'd0);

    // byte loads: little-endian lane 3 is 0x80, lane 2 is 0xFF
    mem_txn(LS_LB, 64'h8000_0003, '0, 64'h0000_0000_80FF_0000, 1, a, w, m, we, ns, st);
    chk("lb3_addr", a, 64'h8000_0000);
    chk("lb3_we", 64'(we), 64'd0);
    chk("lb3_stalls", 64'(ns), 64'd1);
    chk("lb3_valid", 64'(mem_valid), 64'd1);
    chk("lb3_pc", mem_pc, 64'h8000_1112);
    chk("lb3_data", mem_rd_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb3_rdaddr", 64'(mem_rd_addr), 64'd7);
    chk("lb3_ena", 64'(mem_rd_ena), 64'd1);
    mem_txn(LS_LBU, 64'h8000_0003, '0, 64'h0000_0000_80FF_0000, 1, a, w, m, we, ns, st);
    chk("lbu3_data", mem_rd_data, 64'h80);
    mem_txn(LS_LB, 64'h8000_0002, '0, 64'h0000_0000_80FF_0000, 1, a, w, m, we, ns, st);
    chk("lb2_data", mem_rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
    mem_txn(LS_LBU, 64'h8000_0002, '0, 64'h0000_0000_80FF_0000, 1, a, w, m, we, ns, st);
    chk("lbu2_data", mem_rd_data, 64'hFF);

    // halfword store into the top lane
    mem_txn(LS_SH, 64'h8000_0006, 64'hABCD, '0, 1, a, w, m, we, ns, st);
    chk("sh_mask", 64'(m), 64'hC0);
    chk("sh_wdata", w, 64'hABCD_0000_0000_0000);
    chk("sh_we", 64'(we), 64'd1);
    chk("sh_valid", 64'(mem_valid), 64'd1);
    chk("sh_ena", 64'(mem_rd_ena), 64'd0);

    // word / halfword loads, signed and unsigned
    mem_txn(LS_LW, 64'h8000_0004, '0, 64'h8000_0001_0000_0000, 1, a, w, m, we, ns, st);
    chk("lw_data", mem_rd_data, 64'hFFFF_FFFF_8000_0001);
    mem_txn(LS_LWU, 64'h8000_0004, '0, 64'h8000_0001_0000_0000, 1, a, w, m, we, ns, st);
    chk("lwu_data", mem_rd_data, 64'h0000_0000_8000_0001);
    mem_txn(LS_LHU, 64'h8000_0006, '0, 64'hF00D_0000_0000_0000, 1, a, w, m, we, ns, st);
    chk("lhu_data", mem_rd_data, 64'hF00D);

    // doubleword load, ack three cycles late
    mem_txn(LS_LD, 64'h8000_0008, '0, 64'h0123_4567_89AB_CDEF, 3, a, w, m, we, ns, st);
    chk("ld_stalls", 64'(ns), 64'd3);
    chk("ld_stable", 64'(st), 64'd1);
    chk("ld_valid", 64'(mem_valid), 64'd1);
    chk("ld_data", mem_rd_data, 64'h0123_4567_89AB_CDEF);
    tick();
    chk("ld_pulse", 64'(mem_valid), 64'd0);

    // doubleword store, full mask
    mem_txn(LS_SD, 64'h8000_0010, 64'hCAFE_F00D_1234_5678, '0, 2, a, w, m, we, ns, st);
    chk("sd_mask", 64'(m), 64'hFF);
    chk("sd_wdata", w, 64'hCAFE_F00D_1234_5678);
    chk("sd_stalls", 64'(ns), 64'd2);

`ifdef YSYX22040228_MISALIGN_EN
    tick();
    ex_valid = 1'b1; ex_ls_op = LS_LW; ex_addr = 64'h8000_0002; ex_rd_addr = 5'd3;
    ex_rd_ena = 1'b1; ex_pc = 64'h2000;
    #1;
    chk("mis_req", 64'(dmem_req), 64'd0);
    chk("mis_stall", 64'(stall_req), 64'd0);
    tick();
    ex_valid = 1'b0;
    chk("mis_flag", 64'(misalign), 64'd1);
    chk("mis_valid", 64'(mem_valid), 64'd1);
    chk("mis_ena", 64'(mem_rd_ena), 64'd0);
    tick();
    chk("mis_pulse", 64'(misalign), 64'd0);
`else
    // low offset bits are dropped: LW at +2 reads lanes 0..3
    mem_txn(LS_LW, 64'h8000_0002, '0, 64'h1122_3344_AABB_CCDD, 1, a, w, m, we, ns, st);
    chk("lw_trunc_data", mem_rd_data, 64'hFFFF_FFFF_AABB_CCDD);
`endif

    // reset while waiting for an ack, then a late ack
    tick();
    ex_valid = 1'b1; ex_ls_op = LS_LD; ex_addr = 64'h8000_0020; ex_rd_addr = 5'd9;
    #1;
    chk("rw_req", 64'(dmem_req), 64'd1);
    tick();
    rst = 1'b1; ex_valid = 1'b0;
    tick();
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("rw_req_drop", 64'(dmem_req), 64'd0);
    chk("rw_stall", 64'(stall_req), 64'd0);
    chk("rw_valid0", 64'(mem_valid), 64'd0);
    tick();
    dmem_ack = 1'b0;
    chk("rw_valid1", 64'(mem_valid), 64'd0);
    chk("rw_data", mem_rd_data, 64'd0);
    chk("rw_ena", 64'(mem_rd_ena), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
